// File: rtl/mm_busy_watchdog.sv
// Memory-mapped bus watchdog: pass-through that aborts transactions stalled TIMEOUT cycles.
// Optional saturating abort counter enabled by MM_BUSY_WATCHDOG_ERRCNT_EN.
module mm_busy_watchdog #(
  parameter int                AWIDTH    = 8,
  parameter int                DWIDTH    = 8,
  parameter int                TIMEOUT   = 256,
  parameter logic [DWIDTH-1:0] RDDEFAULT = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [AWIDTH-1:0] s_addr,
  input  logic              s_wreq,
  input  logic [DWIDTH-1:0] s_wdat,
  input  logic              s_rreq,
  output logic [DWIDTH-1:0] s_rdat,
  output logic              s_busy,
  output logic [AWIDTH-1:0] m_addr,
  output logic              m_wreq,
  output logic [DWIDTH-1:0] m_wdat,
  output logic              m_rreq,
  input  logic [DWIDTH-1:0] m_rdat,
  input  logic              m_busy,
  output logic              err_pulse,
  output logic [AWIDTH-1:0] err_addr,
  output logic [15:0]       err_cnt
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic {
    RUN   = 1'b0,
    ABORT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req;
  logic          expire;

  assign req = s_wreq | s_rreq;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    expire    = 1'b0;
    m_addr    = s_addr;
    m_wdat    = s_wdat;
    m_wreq    = s_wreq;
    m_rreq    = s_rreq;
    s_busy    = m_busy;
    s_rdat    = m_rdat;
    err_pulse = 1'b0;
    unique case (state_q)
      RUN: begin
        if (req && m_busy) begin
          if (cnt_q == CNT_LAST) begin
            expire  = 1'b1;
            state_d = ABORT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ABORT: begin
        // Complete toward the master while releasing the slave
        state_d   = RUN;
        m_wreq    = 1'b0;
        m_rreq    = 1'b0;
        s_busy    = 1'b0;
        s_rdat    = RDDEFAULT;
        err_pulse = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_addr <= '0;
    end else if (expire) begin
      err_addr <= s_addr;
    end
  end

`ifdef MM_BUSY_WATCHDOG_ERRCNT_EN
  logic [15:0] err_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_cnt_q <= '0;
    end else if (expire && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = '0;
`endif

endmodule
